// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht
//   Resolves branch conditions from the execute stage, registers the outcome
//   and misprediction flag, and trains a direct-mapped table of 2-bit
//   saturating counters that the fetch stage reads for prediction.
//   Saturating statistics count resolved branches and mispredictions.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   lookup_pc       fetch PC to predict      -> pred_taken (combinational)
//   res_valid       resolution request this cycle
//   res_pc          PC of the resolving branch (selects BHT entry)
//   src_a, src_b    branch operands
//   branch_op       condition select (0..10 defined, 11..15 never taken)
//   res_pred        prediction originally used for this branch
//   flush           kills this cycle's resolution
//   out_valid, out_taken, out_mispredict   registered resolution result
//   br_cnt, mis_cnt saturating statistics counters
module branch_resolve_bht #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int IDX_LSB   = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_pc,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       branch_op,
  input  logic             res_pred,
  input  logic             flush,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] lookupIdx;
  logic [IDX_W-1:0] resIdx;
  logic             cond;
  logic             accept;
  logic             aNeg;
  logic             aZero;

  // PC bits outside the index field are intentionally ignored (aliasing).
  logic unusedPcBits;
  assign unusedPcBits = ^{lookup_pc, res_pc};

  assign lookupIdx = lookup_pc[IDX_LSB +: IDX_W];
  assign resIdx    = res_pc[IDX_LSB +: IDX_W];

  // Reads the pre-edge table contents, so a same-cycle update to the same
  // entry only becomes visible after the clock edge.
  assign pred_taken = bht[lookupIdx][1];

  assign accept = res_valid && !flush;

  // Zero tests are done on the sign bit / reduction so no unsized literal
  // can turn the comparison unsigned.
  assign aNeg  = src_a[WIDTH-1];
  assign aZero = ~|src_a;

  always_comb begin
    cond = 1'b0;
    unique case (branch_op)
      4'd0:    cond = (src_a == src_b);
      4'd1:    cond = (src_a != src_b);
      4'd2:    cond = !aNeg && !aZero;
      4'd3:    cond = aNeg || aZero;
      4'd4:    cond = !aNeg;
      4'd5:    cond = aNeg;
      4'd6:    cond = ($signed(src_a) <  $signed(src_b));
      4'd7:    cond = ($signed(src_a) >= $signed(src_b));
      4'd8:    cond = (src_a <  src_b);
      4'd9:    cond = (src_a >= src_b);
      4'd10:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      br_cnt         <= '0;
      mis_cnt        <= '0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_taken      <= cond;
      out_mispredict <= cond ^ res_pred;
      if (cond && bht[resIdx] != 2'b11) begin
        bht[resIdx] <= bht[resIdx] + 2'b01;
      end else if (!cond && bht[resIdx] != 2'b00) begin
        bht[resIdx] <= bht[resIdx] - 2'b01;
      end
      if (br_cnt != '1) begin
        br_cnt <= br_cnt + 1'b1;
      end
      if ((cond ^ res_pred) && mis_cnt != '1) begin
        mis_cnt <= mis_cnt + 1'b1;
      end
    end else begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
    end
  end

endmodule
